mem_responder: RTL and testbench

//  Memory-side responder for the multicycle core's unified instruction/data port.
//  - Accepts word requests: request strobe, address, write data and byte enables.
//  - Serves them from an internal word array after a programmable number of wait states.
//  - Completes each request with a one-cycle ready pulse, plus an error flag.
//  - Sits between the core's Adr/WriteData/ReadData port and on-chip storage.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/mem_array.sv | 38 +++
 rtl/mem_responder.sv | 184 ++++++++++++++++++
 tb/tb_mem_responder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder slice.
//   state_t     : responder FSM states (IDLE, WAIT, RESP)
//   WORD_BYTES  : bytes per stored word
//   CNT_W       : width of the wait-state counter (covers 0..15)
//   be_to_mask  : expands a byte-enable vector into a 32-bit bit mask
package mem_pkg;

    localparam int WORD_BYTES = 4;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [31:0] be_to_mask(input logic [WORD_BYTES-1:0] be);
        logic [31:0] mask;
        mask = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            mask[8*i +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Word storage for mem_responder: DEPTH_WORDS x 32 bits, one shared index,
// synchronous bit-masked write, combinational read. Contents have no reset.
// Ports:
//   clk    in   clock, rising edge
//   we     in   write enable for this cycle
//   idx    in   word index (read and write)
//   wdata  in   write data
//   wmask  in   per-bit write mask (1 = take wdata bit)
//   rdata  out  current word at idx
module mem_array #(
    parameter int DEPTH_WORDS = 64,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    input  logic [31:0]      wmask,
    output logic [31:0]      rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] word_d;

    // Merge new bytes into the existing word so disabled bytes keep their value.
    always_comb begin
        word_d = (mem_q[idx] & ~wmask) | (wdata & wmask);
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= word_d;
        end
    end

    assign rdata = mem_q[idx];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle core's unified port. A request is
// captured in IDLE, held through WAIT_CYCLES wait states, and answered with a
// one-cycle ready pulse (plus err) from an internal word array.
// Optional feature macro: MEM_MISALIGN_ERR_EN -- when defined, a captured
// address with addr[1:0] != 0 completes with err=1 and no array access.
// Ports:
//   clk, reset  clock (rising edge) and asynchronous active-high reset
//   req         request strobe, held by the requester until ready
//   we          1 = write, 0 = read
//   addr        byte address; word index = addr[ADDR_W-1:2]
//   wdata, be   write data and byte enables
//   rdata       registered read data, held until the next read completes
//   ready       one-cycle completion pulse
//   err         error flag, only meaningful while ready=1
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [31:0]           wdata,
    input  logic [WORD_BYTES-1:0] be,
    output logic [31:0]           rdata,
    output logic                  ready,
    output logic                  err
);

    localparam int              IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [WORD_BYTES-1:0] be_q, be_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  cur_we;
    logic [ADDR_W-1:0]     cur_addr;
    logic [31:0]           cur_wdata;
    logic [WORD_BYTES-1:0] cur_be;
    logic [31:0]           cur_mask;
    logic                  commit;
    logic                  range_err;
    logic                  align_err;
    logic                  access_err;
    logic                  arr_we;
    logic [31:0]           arr_rdata;

    // The commit edge can be the capture edge itself (WAIT_CYCLES=0), so in
    // IDLE the live inputs stand in for the not-yet-loaded request registers.
    always_comb begin
        if (state_q == IDLE) begin
            cur_we    = we;
            cur_addr  = addr;
            cur_wdata = wdata;
            cur_be    = be;
        end else begin
            cur_we    = we_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_be    = be_q;
        end
    end

    assign range_err = 64'(cur_addr[ADDR_W-1:2]) >= 64'(DEPTH_WORDS);

`ifdef MEM_MISALIGN_ERR_EN
    assign align_err = (cur_addr[1:0] != 2'b00);
`else
    logic unused_addr_lsb;
    assign align_err       = 1'b0;
    assign unused_addr_lsb = ^cur_addr[1:0];
`endif

    // State register and datapath flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state, wait counter and request capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    be_d    = be;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Access is performed on the edge that enters RESP.
    always_comb begin
        commit     = (state_d == RESP) && (state_q != RESP);
        access_err = range_err | align_err;
        cur_mask   = be_to_mask(cur_be);
        // Gate with reset so a write never lands while reset holds the FSM.
        arr_we     = commit && cur_we && !access_err && !reset;
        rdata_d    = rdata_q;
        err_d      = 1'b0;
        if (commit) begin
            err_d = access_err;
            if (access_err) begin
                rdata_d = '0;
            end else if (!cur_we) begin
                rdata_d = arr_rdata & cur_mask;
            end
        end
    end

    // Outputs.
    always_comb begin
        ready = (state_q == RESP);
        err   = (state_q == RESP) && err_q;
        rdata = rdata_q;
    end

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_mem_array (
        .clk   (clk),
        .we    (arr_we),
        .idx   (cur_addr[IDX_W+1:2]),
        .wdata (cur_wdata),
        .wmask (cur_mask),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a WAIT_CYCLES=2 instance for directed table
// vectors, reset and random traffic, and a WAIT_CYCLES=0 instance for the
// back-to-back sequence.
module tb_mem_responder;

  logic clk = 1'b0;
  logic reset;

  // WAIT_CYCLES=2 instance
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ready, err;

  // WAIT_CYCLES=0 instance
  logic        z_req, z_we;
  logic [31:0] z_addr, z_wdata;
  logic [3:0]  z_be;
  logic [31:0] z_rdata;
  logic        z_ready, z_err;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .be(be), .rdata(rdata), .ready(ready), .err(err)
  );

  mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0), .ADDR_W(32)) dut_w0 (
    .clk(clk), .reset(reset), .req(z_req), .we(z_we), .addr(z_addr),
    .wdata(z_wdata), .be(z_be), .rdata(z_rdata), .ready(z_ready), .err(z_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: word contents and the held read-data value.
  logic [31:0] model_mem [64];
  logic [31:0] model_rd;
  logic [32:0] exp_q [$];

`ifdef MEM_MISALIGN_ERR_EN
  localparam logic [31:0] MIS_RD  = 32'h0;
  localparam logic        MIS_ERR = 1'b1;
`else
  localparam logic [31:0] MIS_RD  = 32'hDEADBEEF;
  localparam logic        MIS_ERR = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [$];

  logic [31:0] got_rd;
  logic        got_err;
  int          lat;
  logic        r_we;
  logic [31:0] r_addr, r_wdata, e_rd;
  logic [3:0]  r_be;
  logic        e_err;
  logic [32:0] exp_v;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic void model_txn(input logic m_we, input logic [31:0] m_addr,
                                    input logic [31:0] m_wdata, input logic [3:0] m_be,
                                    output logic [31:0] m_rd, output logic m_err);
    int   idx;
    logic mis;
    idx = int'(m_addr >> 2);
    mis = 1'b0;
`ifdef MEM_MISALIGN_ERR_EN
    mis = (m_addr[1:0] != 2'b00);
`endif
    m_err = (idx >= 64) || mis;
    if (m_err) begin
      model_rd = 32'h0;
    end else if (m_we) begin
      for (int b = 0; b < 4; b++)
        if (m_be[b]) model_mem[idx][8*b +: 8] = m_wdata[8*b +: 8];
    end else begin
      model_rd = model_mem[idx];
    end
    m_rd = model_rd;
  endfunction

  // Drive one request on the WAIT_CYCLES=2 instance; lat counts edges until ready.
  task automatic do_txn(input logic t_we, input logic [31:0] t_addr, input logic [31:0] t_wdata,
                        input logic [3:0] t_be, output logic [31:0] o_rd, output logic o_err,
                        output int o_lat);
    @(negedge clk);
    req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata; be = t_be;
    o_lat = 0;
    o_rd  = '0;
    o_err = 1'b0;
    do begin
      @(posedge clk); #1;
      o_lat++;
      // Inputs are ignored once captured; scramble them during the wait.
      if (o_lat == 1 && !ready) begin
        we = ~t_we; addr = $urandom; wdata = $urandom; be = 4'($urandom_range(0, 15));
      end
    end while (!ready && o_lat < 40);
    chk("ready_seen", {31'b0, ready}, 32'h1);
    o_rd  = rdata;
    o_err = err;
    @(negedge clk);
    req = 1'b0;
    @(posedge clk); #1;
    chk("ready_one_cycle", {31'b0, ready}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Clock / reset
    reset = 1'b1;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    z_req = 1'b0; z_we = 1'b0; z_addr = '0; z_wdata = '0; z_be = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready",   {31'b0, ready},   32'h0);
    chk("reset_err",     {31'b0, err},     32'h0);
    chk("reset_rdata",   rdata,            32'h0);
    chk("reset_w0_ready",{31'b0, z_ready}, 32'h0);
    chk("reset_w0_rdata",z_rdata,          32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Directed table
    vecs.push_back('{1'b1, 32'h000, 32'h01020304, 4'hF, 32'h00000000, 1'b0});
    vecs.push_back('{1'b1, 32'h00C, 32'hDEADBEEF, 4'hF, 32'h00000000, 1'b0});
    vecs.push_back('{1'b0, 32'h00C, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b1, 32'h014, 32'h11223344, 4'hF, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b1, 32'h014, 32'hAABBCCDD, 4'h5, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b0, 32'h014, 32'h0,        4'hF, 32'h11BB33DD, 1'b0});
    vecs.push_back('{1'b1, 32'h100, 32'hCAFEF00D, 4'hF, 32'h00000000, 1'b1});
    vecs.push_back('{1'b0, 32'h000, 32'h0,        4'hF, 32'h01020304, 1'b0});
    vecs.push_back('{1'b0, 32'h100, 32'h0,        4'hF, 32'h00000000, 1'b1});
    vecs.push_back('{1'b1, 32'h014, 32'hFFFFFFFF, 4'h0, 32'h00000000, 1'b0});
    vecs.push_back('{1'b0, 32'h014, 32'h0,        4'hF, 32'h11BB33DD, 1'b0});
    vecs.push_back('{1'b0, 32'h00E, 32'h0,        4'hF, MIS_RD,       MIS_ERR});
    vecs.push_back('{1'b0, 32'h00C, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, got_rd, got_err, lat);
      chk($sformatf("vec%0d_rdata", i), got_rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), {31'b0, got_err}, {31'b0, vecs[i].exp_err});
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
    end

    // Reset in the middle of WAIT drops the pending write to word 3.
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h0C; wdata = 32'h0BADBAD0; be = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("midreset_ready", {31'b0, ready}, 32'h0);
    chk("midreset_err",   {31'b0, err},   32'h0);
    chk("midreset_rdata", rdata,          32'h0);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    do_txn(1'b0, 32'h0C, 32'h0, 4'hF, got_rd, got_err, lat);
    chk("after_reset_old_word", got_rd, 32'hDEADBEEF);
    chk("after_reset_err", {31'b0, got_err}, 32'h0);

    // Preload every word through the port so the model knows all contents.
    model_rd = 32'hDEADBEEF;
    for (int w = 0; w < 64; w++) begin
      r_wdata = $urandom;
      model_txn(1'b1, 32'(w * 4), r_wdata, 4'hF, e_rd, e_err);
      do_txn(1'b1, 32'(w * 4), r_wdata, 4'hF, got_rd, got_err, lat);
      chk("preload_rdata", got_rd, e_rd);
      chk("preload_err", {31'b0, got_err}, {31'b0, e_err});
    end

    // Random traffic against the model.
    for (int i = 0; i < 80; i++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_addr  = 32'($urandom_range(0, 71) * 4);
      if ($urandom_range(0, 3) == 0) r_addr = r_addr + 32'($urandom_range(1, 3));
      r_wdata = $urandom;
      r_be    = r_we ? 4'($urandom_range(0, 15)) : 4'hF;
      model_txn(r_we, r_addr, r_wdata, r_be, e_rd, e_err);
      exp_q.push_back({e_err, e_rd});
      do_txn(r_we, r_addr, r_wdata, r_be, got_rd, got_err, lat);
      exp_v = exp_q.pop_front();
      chk($sformatf("rand%0d_rdata", i), got_rd, exp_v[31:0]);
      chk($sformatf("rand%0d_err", i), {31'b0, got_err}, {31'b0, exp_v[32]});
      chk($sformatf("rand%0d_latency", i), 32'(lat), 32'd3);
    end

    // WAIT_CYCLES=0: req held high across four back-to-back operations.
    begin
      logic        ops_we  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      logic [31:0] ops_adr [4] = '{32'h4, 32'h8, 32'h4, 32'h8};
      logic [31:0] ops_dat [4] = '{32'hA1A1A1A1, 32'hB2B2B2B2, 32'h0, 32'h0};
      logic [31:0] ops_exp [4] = '{32'h0, 32'h0, 32'hA1A1A1A1, 32'hB2B2B2B2};
      int   k;
      logic prev_rdy;
      k = 0;
      prev_rdy = 1'b0;
      @(negedge clk);
      z_req = 1'b1; z_we = ops_we[0]; z_addr = ops_adr[0]; z_wdata = ops_dat[0]; z_be = 4'hF;
      for (int cyc = 1; cyc <= 8; cyc++) begin
        @(posedge clk); #1;
        chk($sformatf("w0_ready_c%0d", cyc), {31'b0, z_ready}, 32'(cyc % 2));
        chk("w0_no_consecutive", {31'b0, z_ready & prev_rdy}, 32'h0);
        if (z_ready && k < 4 && !ops_we[k]) begin
          chk($sformatf("w0_rdata_op%0d", k), z_rdata, ops_exp[k]);
          chk($sformatf("w0_err_op%0d", k), {31'b0, z_err}, 32'h0);
        end
        prev_rdy = z_ready;
        @(negedge clk);
        if (z_ready) begin
          k++;
          if (k < 4) begin
            z_we = ops_we[k]; z_addr = ops_adr[k]; z_wdata = ops_dat[k];
          end else begin
            z_req = 1'b0;
          end
        end
      end
      chk("w0_ops_done", 32'(k), 32'd4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
